phy_tx: RTL and testbench

// Two-lane byte-to-serial transmitter at the clk_8f bit rate; the transmit counterpart of the phy_rx deserializer.

---
 rtl/phy_tx_if.sv | 26 ++
 rtl/phy_tx.sv | 81 ++++++++
 tb/tb_phy_tx.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/phy_tx_if.sv
// phy_tx_if: two-lane transmit bus between a byte source and phy_tx.
//   data_in_0/1, valid_in_0/1 : per-lane byte and valid from the source
//   ready_out                 : slot-accept strobe from the transmitter
//   active_out                : transmitter has finished its sync sequence
//   data_out0/1               : per-lane serial bit from the transmitter
// master = byte source side, slave = transmitter side.
interface phy_tx_if;
  logic [7:0] data_in_0;
  logic       valid_in_0;
  logic [7:0] data_in_1;
  logic       valid_in_1;
  logic       ready_out;
  logic       active_out;
  logic       data_out0;
  logic       data_out1;

  modport master (
    output data_in_0, valid_in_0, data_in_1, valid_in_1,
    input  ready_out, active_out, data_out0, data_out1
  );

  modport slave (
    input  data_in_0, valid_in_0, data_in_1, valid_in_1,
    output ready_out, active_out, data_out0, data_out1
  );
endinterface

// File: rtl/phy_tx.sv
// phy_tx: two-lane byte-to-serial transmitter running at the clk_8f bit rate.
// Each lane shifts one byte out MSB first every 8 clocks. After reset both
// lanes send SYNC_WORDS copies of IDLE_CHAR, then every byte slot carries the
// lane's valid byte or IDLE_CHAR when none was offered.
//   clk_8f : bit clock, all state on posedge
//   reset  : asynchronous, active-low
//   bus    : phy_tx_if.slave (byte inputs, ready/active strobes, serial outputs)
module phy_tx #(
  parameter logic [7:0]  IDLE_CHAR  = 8'hBC,
  parameter int unsigned SYNC_WORDS = 4
) (
  input  logic     clk_8f,
  input  logic     reset,
  phy_tx_if.slave  bus
);

  typedef enum logic {SYNC, ACTIVE} state_t;

  localparam logic [4:0] SYNC_LAST = 5'(SYNC_WORDS - 1);

  state_t     state;
  logic [2:0] bit_cnt;
  logic [3:0] sync_cnt;
  logic [7:0] hold_0;
  logic [7:0] hold_1;
  logic       dout0_r;
  logic       dout1_r;
  logic       ready_r;
  logic       active_r;
  logic       load;
  logic       slot_open;
  logic       sync_done;

  assign load = (bit_cnt == 3'd7);

  // The load edge that fetches word SYNC_WORDS is a data slot. Normally that
  // happens in ACTIVE; with SYNC_WORDS=1 the reset-loaded word is the only
  // sync word, so the very first load edge is already a data slot.
  assign slot_open = (state == ACTIVE) || ({1'b0, sync_cnt} == SYNC_LAST);

  // True on the load edge that fetches word SYNC_WORDS-1 (or later).
  assign sync_done = ({1'b0, sync_cnt} + 5'd1) >= SYNC_LAST;

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state    <= SYNC;
      bit_cnt  <= '0;
      sync_cnt <= '0;
      hold_0   <= IDLE_CHAR;
      hold_1   <= IDLE_CHAR;
      dout0_r  <= 1'b0;
      dout1_r  <= 1'b0;
      ready_r  <= 1'b0;
      active_r <= 1'b0;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
      dout0_r <= hold_0[3'd7 - bit_cnt];
      dout1_r <= hold_1[3'd7 - bit_cnt];
      // Registered strobe: raised one edge early so it is high in the cycle
      // that ends in the load edge. slot_open only changes on load edges.
      ready_r <= (bit_cnt == 3'd6) && slot_open;
      if (load) begin
        hold_0 <= (slot_open && bus.valid_in_0) ? bus.data_in_0 : IDLE_CHAR;
        hold_1 <= (slot_open && bus.valid_in_1) ? bus.data_in_1 : IDLE_CHAR;
        if (state == SYNC) begin
          sync_cnt <= sync_cnt + 4'd1;
          if (sync_done) begin
            state    <= ACTIVE;
            active_r <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.data_out0  = dout0_r;
  assign bus.data_out1  = dout1_r;
  assign bus.ready_out  = ready_r;
  assign bus.active_out = active_r;

endmodule

// File: tb/tb_phy_tx.sv
module tb_phy_tx;

  localparam logic [7:0] IDLE = 8'hBC;

  logic clk_8f = 1'b0;
  logic reset  = 1'b0;

  always #5 clk_8f = ~clk_8f;

  phy_tx_if bus  ();
  phy_tx_if busb ();

  phy_tx #(.IDLE_CHAR(8'hBC), .SYNC_WORDS(4)) dut (
    .clk_8f (clk_8f),
    .reset  (reset),
    .bus    (bus)
  );

  phy_tx #(.IDLE_CHAR(8'hBC), .SYNC_WORDS(1)) dut_b (
    .clk_8f (clk_8f),
    .reset  (reset),
    .bus    (busb)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  logic        mon_en = 1'b0;
  logic        b_go   = 1'b0;
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];

  task automatic chk(input string nm, input int unsigned e, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %b, expected %b", nm, e, act, exp);
  endtask

  // Offers one byte per lane in the next ready cycle and queues the word the
  // wire must carry in that slot.
  task automatic slot(input logic v0, input logic [7:0] d0,
                      input logic v1, input logic [7:0] d1);
    int unsigned n = 0;
    do begin
      @(negedge clk_8f);
      n++;
    end while (bus.ready_out !== 1'b1 && n < 40);
    if (bus.ready_out !== 1'b1) begin
      n_chk++;
      $display("FAIL ready_timeout: ready_out not seen within %0d cycles", n);
      return;
    end
    bus.valid_in_0 = v0;
    bus.data_in_0  = d0;
    bus.valid_in_1 = v1;
    bus.data_in_1  = d1;
    q0.push_back(v0 ? d0 : IDLE);
    q1.push_back(v1 ? d1 : IDLE);
    @(posedge clk_8f);
    #1;
    bus.valid_in_0 = 1'b0;
    bus.data_in_0  = 8'h00;
    bus.valid_in_1 = 1'b0;
    bus.data_in_1  = 8'h00;
  endtask

  task automatic push_sync();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(IDLE);
      q1.push_back(IDLE);
    end
  endtask

  // Monitor for the SYNC_WORDS=4 instance: pops one expected word per lane at
  // each word start and compares every serial bit, plus the ready/active pattern.
  initial begin : monitor
    int unsigned edge_n = 0;
    int unsigned bit_i;
    logic [7:0]  w0 = IDLE;
    logic [7:0]  w1 = IDLE;
    forever begin
      @(negedge clk_8f);
      if (!mon_en) begin
        edge_n = 0;
      end else begin
        edge_n++;
        bit_i = (edge_n - 1) % 8;
        if (bit_i == 0) begin
          if (q0.size() == 0 || q1.size() == 0) begin
            n_chk++;
            $display("FAIL sb_underflow at edge %0d: got no queued word, expected one", edge_n);
            w0 = IDLE;
            w1 = IDLE;
          end else begin
            w0 = q0.pop_front();
            w1 = q1.pop_front();
          end
        end
        chk("lane0_bit", edge_n, bus.data_out0, w0[7 - bit_i]);
        chk("lane1_bit", edge_n, bus.data_out1, w1[7 - bit_i]);
        chk("ready_out", edge_n, bus.ready_out, (edge_n >= 31) && (edge_n % 8 == 7));
        if (edge_n <= 23) chk("active_low", edge_n, bus.active_out, 1'b0);
        if (edge_n >= 32) chk("active_high", edge_n, bus.active_out, 1'b1);
      end
    end
  end

  // SYNC_WORDS=1 instance: ready in cycle 7->8, byte loaded at edge 8 shows from edge 9.
  initial begin : check_b
    logic [7:0] e0;
    logic [7:0] e1;
    busb.valid_in_0 = 1'b0;
    busb.data_in_0  = 8'h00;
    busb.valid_in_1 = 1'b0;
    busb.data_in_1  = 8'h00;
    wait (b_go);
    for (int unsigned k = 1; k <= 16; k++) begin
      @(negedge clk_8f);
      e0 = (k <= 8) ? IDLE : 8'h5A;
      e1 = (k <= 8) ? IDLE : 8'hC3;
      chk("b_ready", k, busb.ready_out, (k % 8) == 7);
      chk("b_lane0_bit", k, busb.data_out0, e0[7 - ((k - 1) % 8)]);
      chk("b_lane1_bit", k, busb.data_out1, e1[7 - ((k - 1) % 8)]);
      if (k == 7) begin
        busb.valid_in_0 = 1'b1;
        busb.data_in_0  = 8'h5A;
        busb.valid_in_1 = 1'b1;
        busb.data_in_1  = 8'hC3;
      end
      if (k == 8) begin
        busb.valid_in_0 = 1'b0;
        busb.data_in_0  = 8'h00;
        busb.valid_in_1 = 1'b0;
        busb.data_in_1  = 8'h00;
      end
    end
  end

  initial begin : stimulus
    bus.valid_in_0 = 1'b0;
    bus.data_in_0  = 8'h00;
    bus.valid_in_1 = 1'b0;
    bus.data_in_1  = 8'h00;

    repeat (3) @(negedge clk_8f);
    chk("rst_out0",   0, bus.data_out0,  1'b0);
    chk("rst_out1",   0, bus.data_out1,  1'b0);
    chk("rst_ready",  0, bus.ready_out,  1'b0);
    chk("rst_active", 0, bus.active_out, 1'b0);

    push_sync();
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;
    b_go   = 1'b1;

    slot(1'b1, 8'hA5, 1'b0, 8'h99);
    slot(1'b1, 8'h00, 1'b1, 8'hFF);
    slot(1'b1, 8'hFF, 1'b1, 8'h00);
    // Off-slot valid pulse on lane 1 must not reach the wire.
    @(negedge clk_8f);
    bus.valid_in_1 = 1'b1;
    bus.data_in_1  = 8'h3C;
    @(negedge clk_8f);
    bus.valid_in_1 = 1'b0;
    bus.data_in_1  = 8'h00;
    slot(1'b0, 8'h55, 1'b0, 8'hAA);
    slot(1'b1, IDLE,  1'b1, 8'h66);

    // Reset in the middle of a data byte.
    slot(1'b1, 8'hF0, 1'b1, 8'h0F);
    repeat (4) @(posedge clk_8f);
    #2;
    chk("pre_rst_out0", 0, bus.data_out0, 1'b1);
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    chk("mid_rst_out0",   0, bus.data_out0,  1'b0);
    chk("mid_rst_out1",   0, bus.data_out1,  1'b0);
    chk("mid_rst_ready",  0, bus.ready_out,  1'b0);
    chk("mid_rst_active", 0, bus.active_out, 1'b0);
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk_8f);
    push_sync();
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;

    slot(1'b1, 8'h81, 1'b1, 8'h7E);
    repeat (8) @(negedge clk_8f);
    #2;
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
